// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift-register block.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam logic SPI_LSB_FIRST = 1'b1;
  localparam logic SPI_MSB_FIRST = 1'b0;

endpackage

// File: rtl/spi_shreg_if.sv
// Signal bundle between the SPI edge generator / register file and spi_shreg.
interface spi_shreg_if #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) ();

  logic          ld;
  logic [DW-1:0] ld_data;
  logic          lsb_first;
  logic          din;
  logic          smp;
  logic          sh;
  logic          dout;
  logic [DW-1:0] dstr;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;

  modport master (
    output ld, ld_data, lsb_first, din, smp, sh,
    input  dout, dstr, busy, done, bit_cnt
  );

  modport slave (
    input  ld, ld_data, lsb_first, din, smp, sh,
    output dout, dstr, busy, done, bit_cnt
  );

endinterface

// File: rtl/spi_bitcnt.sv
// Bit counter with clear, enable and terminal-count (count == DW) flag.
module spi_bitcnt #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(DW));

endmodule

// File: rtl/spi_shreg.sv
// Parametrised SPI data shift register: LSB/MSB-first, separate sample and
// shift strobes, internal bit counter with busy/done handshake.
module spi_shreg
  import spi_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic        clk,
  input  logic        rst,
  spi_shreg_if.slave  bus
);

  spi_state_e    r_state;
  spi_state_e    w_state_next;
  logic [DW-1:0] r_shr;
  logic [DW-1:0] r_dstr;
  logic          r_samp;
  logic          r_mode;
  logic          r_done;

  logic [CW-1:0] w_cnt;
  logic          w_tc;
  logic          w_active;
  logic          w_sh;
  logic          w_smp;
  logic          w_bit;
  logic          w_last;
  logic [DW-1:0] w_shr_next;

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] s,
                                             input logic b,
                                             input logic m);
    if (m == SPI_LSB_FIRST) return {b, s[DW-1:1]};
    else                    return {s[DW-2:0], b};
  endfunction

  // A load outranks both strobes; strobes only act while a word is in flight.
  assign w_active   = (r_state == SHIFT);
  assign w_sh       = w_active && bus.sh && !w_tc && !bus.ld;
  assign w_smp      = w_active && bus.smp && !bus.ld;
  assign w_bit      = bus.smp ? bus.din : r_samp;
  assign w_shr_next = shift_in(r_shr, w_bit, r_mode);
  assign w_last     = w_sh && (w_cnt == CW'(DW - 1));

  spi_bitcnt #(
    .DW (DW),
    .CW (CW)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (bus.ld),
    .i_en  (w_sh),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.ld)      w_state_next = SHIFT;
    else if (w_last) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shr  <= '0;
      r_dstr <= '0;
      r_samp <= 1'b0;
      r_mode <= SPI_LSB_FIRST;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (bus.ld) begin
        r_shr  <= bus.ld_data;
        r_mode <= bus.lsb_first;
        r_samp <= 1'b0;
      end else begin
        if (w_smp)  r_samp <= bus.din;
        if (w_sh)   r_shr  <= w_shr_next;
        if (w_last) r_dstr <= w_shr_next;
      end
    end
  end

  assign bus.dout    = (r_mode == SPI_LSB_FIRST) ? r_shr[0] : r_shr[DW-1];
  assign bus.dstr    = r_dstr;
  assign bus.busy    = w_active;
  assign bus.done    = r_done;
  assign bus.bit_cnt = w_cnt;

endmodule

// File: doc/spi_shreg.md
# spi_shreg

Parametrised SPI data shift register: the next generation of the 8-bit SPI shifter. It adds configurable word width, run-time LSB/MSB-first selection, separate sample and shift strobes for all four SPI clock modes, and an internal bit counter with busy/done handshake. It sits between the SPI clock-edge generator, which drives `smp`/`sh`, and the Wishbone register file, which drives `ld` and reads `dstr`.

## Interface
- `DW`, default 8: data word width in bits; legal range DW ≥ 2.
- `CW`, default $clog2(DW+1): bit-counter width. Derived; do not override.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld`  in  1  load strobe: start a new word.
- `ld_data`  in  DW  word to transmit; captured on `ld`.
- `lsb_first`  in  1  bit-order select; captured on `ld`.
- `din`  in  1  serial input (MISO/MOSI, depending on role).
- `smp`  in  1  sample strobe: capture `din`.
- `sh`  in  1  shift strobe: shift the sampled bit in and advance the counter.
- `dout`  out  1  current outgoing bit.
- `dstr`  out  DW  last completed received word (registered).
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `bit_cnt`  out  CW  bits shifted in the current word.

## Operation
- State: `IDLE` (busy=0) and `SHIFT` (busy=1).
- `ld` in either state:
  - `shr` ← `ld_data`
  - `mode` ← `lsb_first`
  - `bit_cnt` ← 0
  - `samp` ← 0
  - → `SHIFT`
- `smp` in `SHIFT`: `samp` ← `din`.
- `sh` in `SHIFT`: the shifted-in bit b is `din` if `smp` is also high this cycle, else `samp`.
  - LSB-first: `shr` ← {b, shr[DW-1:1]}.
  - MSB-first: `shr` ← {shr[DW-2:0], b}.
  - `bit_cnt` increments by 1.
- Completion: the `sh` that takes `bit_cnt` from DW-1 to DW also does the following on the same edge:
  - `dstr` ← new shr value
  - `done` ← 1
  - `busy` ← 0
  - → `IDLE`
- `dout`:
  - LSB-first: shr[0].
  - MSB-first: shr[DW-1].
  - Combinational from registers only; no `din` path.
- Received word is in natural bit order in both modes; the first-received bit ends at the LSB (LSB-first) or MSB (MSB-first).
- Ignored inputs:
  - `smp` and `sh` in `IDLE`; `shr`, `samp` and `bit_cnt` hold.
  - `lsb_first` changes outside an `ld` cycle.
- Priority: `rst` > `ld` > `sh`/`smp`.
  - `ld` during `SHIFT` aborts the current word: no `done`, `dstr` unchanged.
- `ld` and the completing `sh` in the same cycle: the load wins; no `done`, `dstr` unchanged.
- After completion, `shr` holds the received word; `dout` reflects it until the next `ld`.

## Timing
- Reset values:
  - `shr`, `samp`, `dstr`, `bit_cnt` = 0
  - `busy`, `done` = 0
  - `mode` = 1 (LSB-first)
  - `dout` = 0
- `ld` at edge n: `busy` = 1 and `dout` = first bit from edge n.
- Each `sh` at edge k: the new `dout` is valid after edge k.
- `done` is high for exactly the one cycle following the completing edge; `dstr` is valid from that same cycle and holds until the next completion or `rst`.
- Minimum transfer: `ld` plus DW `sh` cycles. Back-to-back words are allowed: `ld` may come in the cycle `done` is high.
- `rst` mid-word returns to the reset values on the next edge; `dstr` is cleared.

## Structure
- Shared package `spi_pkg`: state enum (`IDLE`, `SHIFT`) and the bit-order constants `SPI_LSB_FIRST` = 1, `SPI_MSB_FIRST` = 0.
- One sub-module: `spi_bitcnt`, a CW-bit counter with clear, enable and terminal-count (== DW) output, parametrised by DW.
- Datapath, sample flop and FSM stay in `spi_shreg`.

## Test plan
- **LSB-first loopback.** DW=8, lsb_first=1, ld_data=0xC1, `din`=`dout`, 8 `smp`→`sh` pairs.
  - `dout` sequence is 1,0,0,0,0,0,1,1.
  - `dstr`=0xC1; `done` pulses once, one cycle after the 8th `sh`; `busy` falls on the same edge.
- **MSB-first loopback.** Same as above with lsb_first=0.
  - `dout` sequence is 1,1,0,0,0,0,0,1.
  - `dstr`=0xC1.
- **Independent receive.** ld_data=0x00, `din` drives 0x5A MSB-first, `smp` and `sh` in the same cycle (bypass path).
  - `dstr`=0x5A.
  - `bit_cnt` counts 1..8, then holds 8 in `IDLE` until the next `ld`.
- **Abort.** `ld` 0xFF, 3 shifts, then `ld` 0x0F.
  - No `done`; `dstr` keeps its previous value.
  - `bit_cnt`=0; `dout` shows the first bit of 0x0F.
- **Reset mid-word.** `rst` after 5 shifts.
  - All outputs return to reset values next cycle.
  - Later `smp`/`sh` without `ld` change nothing.
- **DW=16 with simultaneous `ld` + final `sh`.**
  - The new word loads; no `done`.
  - A subsequent full 16-bit loopback of 0xBEEF yields `dstr`=0xBEEF.
